// File: rtl/rsa_engine_cached_pkg.sv
// Shared types and constants for the cached RSA modular-exponentiation engine.
package rsa_engine_cached_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_PRECOMP, ST_EXP, ST_OUT} rsa_eng_state_t;

  // Sequencer phases of the Montgomery exponentiation stage.
  typedef enum logic [2:0] {MX_IDLE, MX_TOM, MX_ONE, MX_SQ, MX_MUL, MX_FROM, MX_DONE} mx_phase_t;

  // Operand bits consumed per cycle by the bit-serial Montgomery multiplier.
  localparam int MM_DIGIT = 8;

  // Exponent for the R^2 mod N precompute, R = 2^w.
  function automatic int unsigned precomp_power(input int unsigned w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/rsa_base_cache.sv
// Single-entry cache of the last precomputed Montgomery base, keyed by modulus.
module rsa_base_cache #(
  parameter int W  = 256,
  parameter bit EN = 1'b1
)(
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_lookup_mod,
  output logic         o_hit,
  output logic [W-1:0] o_base,
  input  logic         i_upd,
  input  logic [W-1:0] i_upd_mod,
  input  logic [W-1:0] i_upd_base
);
  logic         vld_q, vld_d;
  logic [W-1:0] mod_q, mod_d, base_q, base_d;

  always_comb begin
    vld_d = vld_q; mod_d = mod_q; base_d = base_q;
    if (i_upd) begin vld_d = 1'b1; mod_d = i_upd_mod; base_d = i_upd_base; end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin vld_q <= 1'b0; mod_q <= '0; base_q <= '0; end
    else begin vld_q <= vld_d; mod_q <= mod_d; base_q <= base_d; end
  end

  assign o_hit  = EN && vld_q && (mod_q == i_lookup_mod);
  assign o_base = base_q;
endmodule

// File: rtl/rsa_mont_exp.sv
// Montgomery exponentiation: msg^key mod N given i_base = R^2 mod N, MSB-first square-and-multiply.
module rsa_mont_exp import rsa_engine_cached_pkg::*; #(
  parameter int W = 256
)(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [W-1:0] i_base,
  input  logic [W-1:0] i_msg,
  input  logic [W-1:0] i_key,
  input  logic [W-1:0] i_modulus,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] o_result
);
  localparam int NDIG = W / MM_DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam int BW   = $clog2(W);

  mx_phase_t      ph_q, ph_d;
  logic [W-1:0]   mod_q, mod_d, key_q, key_d, base_q, base_d, mbar_q, mbar_d, res_q, res_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, a_n, opa, opb, mm_out;
  logic [W+1:0]   t_q, t_d, t_n;
  logic [CW-1:0]  dcnt_q, dcnt_d;
  logic [BW-1:0]  bidx_q, bidx_d;
  logic           ld, nxt;

  always_comb begin
    ph_d = ph_q; mod_d = mod_q; key_d = key_q; base_d = base_q; mbar_d = mbar_q; res_d = res_q;
    a_d = a_q; b_d = b_q; t_d = t_q; dcnt_d = dcnt_q; bidx_d = bidx_q;
    ld = 1'b0; nxt = 1'b0; opa = '0; opb = '0;
    // Radix-2 Montgomery steps; t stays below b + N so W+2 bits suffice.
    t_n = t_q; a_n = a_q;
    for (int j = 0; j < MM_DIGIT; j++) begin
      if (a_n[0]) t_n = t_n + {2'b0, b_q};
      if (t_n[0]) t_n = t_n + {2'b0, mod_q};
      t_n = t_n >> 1;
      a_n = a_n >> 1;
    end
    mm_out = (t_q >= {2'b0, mod_q}) ? W'(t_q - {2'b0, mod_q}) : t_q[W-1:0];
    case (ph_q)
      MX_IDLE: if (i_valid) begin
        mod_d = i_modulus; key_d = i_key; base_d = i_base;
        ph_d = MX_TOM; ld = 1'b1; opa = i_msg; opb = i_base;
      end
      MX_DONE: if (o_ready) ph_d = MX_IDLE;
      default: if (dcnt_q != '0) begin
        a_d = a_n; t_d = t_n; dcnt_d = dcnt_q - CW'(1);
      end else begin
        case (ph_q)
          MX_TOM:  begin mbar_d = mm_out; ph_d = MX_ONE; ld = 1'b1; opa = W'(1); opb = base_q; end
          MX_ONE:  begin ph_d = MX_SQ; bidx_d = BW'(W - 1); ld = 1'b1; opa = mm_out; opb = mm_out; end
          MX_SQ:   if (key_q[bidx_q]) begin ph_d = MX_MUL; ld = 1'b1; opa = mm_out; opb = mbar_q; end
                   else nxt = 1'b1;
          MX_MUL:  nxt = 1'b1;
          default: begin res_d = mm_out; ph_d = MX_DONE; end
        endcase
      end
    endcase
    if (nxt) begin
      ld = 1'b1; opa = mm_out;
      if (bidx_q == '0) begin ph_d = MX_FROM; opb = W'(1); end
      else begin ph_d = MX_SQ; bidx_d = bidx_q - BW'(1); opb = mm_out; end
    end
    if (ld) begin a_d = opa; b_d = opb; t_d = '0; dcnt_d = CW'(NDIG); end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q <= MX_IDLE; mod_q <= '0; key_q <= '0; base_q <= '0; mbar_q <= '0; res_q <= '0;
      a_q <= '0; b_q <= '0; t_q <= '0; dcnt_q <= '0; bidx_q <= '0;
    end else begin
      ph_q <= ph_d; mod_q <= mod_d; key_q <= key_d; base_q <= base_d; mbar_q <= mbar_d; res_q <= res_d;
      a_q <= a_d; b_q <= b_d; t_q <= t_d; dcnt_q <= dcnt_d; bidx_q <= bidx_d;
    end
  end

  assign i_ready  = (ph_q == MX_IDLE);
  assign o_valid  = (ph_q == MX_DONE);
  assign o_result = res_q;
endmodule

// File: rtl/rsa_pow2_mod.sv
// Computes 2^i_power mod i_modulus by repeated modular doubling, one doubling per cycle.
module rsa_pow2_mod #(
  parameter int W  = 256,
  parameter int PW = 10
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [W-1:0]  i_modulus,
  input  logic [PW-1:0] i_power,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [W-1:0]  o_result
);
  logic          busy_q, busy_d, done_q, done_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  mod_q, mod_d, r_q, r_d;
  logic [W:0]    dbl;

  always_comb begin
    busy_d = busy_q; done_d = done_q; cnt_d = cnt_q; mod_d = mod_q; r_d = r_q;
    dbl = {r_q, 1'b0};
    if (dbl >= {1'b0, mod_q}) dbl = dbl - {1'b0, mod_q};
    if (i_valid && i_ready) begin
      busy_d = 1'b1; cnt_d = i_power; mod_d = i_modulus;
      r_d = (i_modulus == W'(1)) ? '0 : W'(1);
    end else if (busy_q) begin
      if (cnt_q == '0) begin busy_d = 1'b0; done_d = 1'b1; end
      else begin r_d = dbl[W-1:0]; cnt_d = cnt_q - PW'(1); end
    end else if (done_q && o_ready) done_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0; done_q <= 1'b0; cnt_q <= '0; mod_q <= '0; r_q <= '0;
    end else begin
      busy_q <= busy_d; done_q <= done_d; cnt_q <= cnt_d; mod_q <= mod_d; r_q <= r_d;
    end
  end

  assign i_ready  = !busy_q && !done_q;
  assign o_valid  = done_q;
  assign o_result = r_q;
endmodule

// File: rtl/rsa_engine_cached.sv
// RSA engine: precompute + Montgomery exponentiation behind one valid/ready pair, with base cache.
module rsa_engine_cached import rsa_engine_cached_pkg::*; #(
  parameter int WIDTH    = 256,
  parameter int TAG_W    = 4,
  parameter bit CACHE_EN = 1'b1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [WIDTH-1:0] i_msg,
  input  logic [WIDTH-1:0] i_key,
  input  logic [WIDTH-1:0] i_modulus,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [WIDTH-1:0] o_crypto,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_err,
  output logic             o_cache_hit
);
  localparam int PW = $clog2(2 * WIDTH) + 1;

  rsa_eng_state_t   st_q, st_d;
  logic [WIDTH-1:0] msg_q, msg_d, key_q, key_d, mod_q, mod_d, base_q, base_d, res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             err_q, err_d, hit_q, hit_d, pc_req_q, pc_req_d, me_req_q, me_req_d;
  logic             pc_ready, pc_ovalid, me_ready, me_ovalid, c_hit, c_upd;
  logic [WIDTH-1:0] pc_res, me_res, c_base;

  always_comb begin
    st_d = st_q; msg_d = msg_q; key_d = key_q; mod_d = mod_q; base_d = base_q; res_d = res_q;
    tag_d = tag_q; err_d = err_q; hit_d = hit_q; pc_req_d = pc_req_q; me_req_d = me_req_q;
    c_upd = 1'b0;
    case (st_q)
      ST_IDLE: if (i_valid) begin
        msg_d = i_msg; key_d = i_key; mod_d = i_modulus; tag_d = i_tag;
        err_d = 1'b0; hit_d = 1'b0; res_d = '0;
        // Even modulus passes through EXP as a one-cycle bubble without launching the engine.
        if (!i_modulus[0]) begin err_d = 1'b1; st_d = ST_EXP; end
        else if (c_hit) begin hit_d = 1'b1; base_d = c_base; me_req_d = 1'b1; st_d = ST_EXP; end
        else begin pc_req_d = 1'b1; st_d = ST_PRECOMP; end
      end
      ST_PRECOMP: begin
        if (pc_ready) pc_req_d = 1'b0;
        if (pc_ovalid) begin c_upd = 1'b1; base_d = pc_res; me_req_d = 1'b1; st_d = ST_EXP; end
      end
      ST_EXP: begin
        if (me_ready) me_req_d = 1'b0;
        if (me_ovalid) res_d = me_res;
        if (err_q || me_ovalid) st_d = ST_OUT;
      end
      default: if (o_ready) st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q <= ST_IDLE; msg_q <= '0; key_q <= '0; mod_q <= '0; base_q <= '0; res_q <= '0;
      tag_q <= '0; err_q <= 1'b0; hit_q <= 1'b0; pc_req_q <= 1'b0; me_req_q <= 1'b0;
    end else begin
      st_q <= st_d; msg_q <= msg_d; key_q <= key_d; mod_q <= mod_d; base_q <= base_d; res_q <= res_d;
      tag_q <= tag_d; err_q <= err_d; hit_q <= hit_d; pc_req_q <= pc_req_d; me_req_q <= me_req_d;
    end
  end

  rsa_base_cache #(.W(WIDTH), .EN(CACHE_EN)) u_cache (
    .clk(clk), .rst(rst), .i_lookup_mod(i_modulus), .o_hit(c_hit), .o_base(c_base),
    .i_upd(c_upd), .i_upd_mod(mod_q), .i_upd_base(pc_res)
  );

  rsa_pow2_mod #(.W(WIDTH), .PW(PW)) u_pow2 (
    .clk(clk), .rst(rst), .i_valid(pc_req_q), .i_ready(pc_ready), .i_modulus(mod_q),
    .i_power(PW'(precomp_power(WIDTH))), .o_valid(pc_ovalid), .o_ready(st_q == ST_PRECOMP),
    .o_result(pc_res)
  );

  rsa_mont_exp #(.W(WIDTH)) u_mexp (
    .clk(clk), .rst(rst), .i_valid(me_req_q), .i_ready(me_ready), .i_base(base_q), .i_msg(msg_q),
    .i_key(key_q), .i_modulus(mod_q), .o_valid(me_ovalid), .o_ready(st_q == ST_EXP),
    .o_result(me_res)
  );

  assign i_ready     = (st_q == ST_IDLE);
  assign o_valid     = (st_q == ST_OUT);
  assign o_crypto    = res_q;
  assign o_tag       = tag_q;
  assign o_err       = err_q;
  assign o_cache_hit = hit_q;
endmodule

// File: tb/tb_rsa_engine_cached.sv
// Scoreboard bench: an 8-bit cached engine for directed cases and a 256-bit uncached one vs a golden model.
module tb_rsa_engine_cached;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic         s_ivalid = 1'b0, s_iready, s_ovalid, s_oready = 1'b1, s_err, s_hit;
  logic [7:0]   s_msg = '0, s_key = '0, s_mod = '0, s_crypto;
  logic [3:0]   s_tag = '0, s_otag;
  logic         b_ivalid = 1'b0, b_iready, b_ovalid, b_oready = 1'b1, b_err, b_hit;
  logic [255:0] b_msg = '0, b_key = '0, b_mod = '0, b_crypto;
  logic [3:0]   b_tag = '0, b_otag;

  rsa_engine_cached #(.WIDTH(8), .TAG_W(4), .CACHE_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .i_valid(s_ivalid), .i_ready(s_iready), .i_msg(s_msg), .i_key(s_key),
    .i_modulus(s_mod), .i_tag(s_tag), .o_valid(s_ovalid), .o_ready(s_oready), .o_crypto(s_crypto),
    .o_tag(s_otag), .o_err(s_err), .o_cache_hit(s_hit));

  rsa_engine_cached #(.WIDTH(256), .TAG_W(4), .CACHE_EN(1'b0)) u_big (
    .clk(clk), .rst(rst), .i_valid(b_ivalid), .i_ready(b_iready), .i_msg(b_msg), .i_key(b_key),
    .i_modulus(b_mod), .i_tag(b_tag), .o_valid(b_ovalid), .o_ready(b_oready), .o_crypto(b_crypto),
    .o_tag(b_otag), .o_err(b_err), .o_cache_hit(b_hit));

  typedef struct { logic [3:0] tag; logic [255:0] crypto; logic err; logic hit; } exp_t;
  exp_t sb_q[$];
  int n_tests = 0, n_fail = 0;
  bit cur_big = 1'b0;

  logic         m_ov, m_ir, m_oe, m_oh;
  logic [255:0] m_oc;
  logic [3:0]   m_ot;
  assign m_ov = cur_big ? b_ovalid : s_ovalid;
  assign m_ir = cur_big ? b_iready : s_iready;
  assign m_oe = cur_big ? b_err : s_err;
  assign m_oh = cur_big ? b_hit : s_hit;
  assign m_oc = cur_big ? b_crypto : 256'(s_crypto);
  assign m_ot = cur_big ? b_otag : s_otag;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] gold(input logic [255:0] m, input logic [255:0] k, input logic [255:0] n);
    logic [511:0] r, b, nn;
    nn = {256'b0, n}; r = 512'd1 % nn; b = {256'b0, m} % nn;
    for (int i = 255; i >= 0; i--) begin
      r = (r * r) % nn;
      if (k[i]) r = (r * b) % nn;
    end
    return r[255:0];
  endfunction

  // Drives one job; returns right after the handshake edge.
  task automatic send(input bit big, input bit push, input logic [255:0] m, input logic [255:0] k,
                      input logic [255:0] n, input logic [3:0] t, input logic [255:0] ec,
                      input logic ee, input logic eh);
    exp_t e;
    int guard = 0;
    cur_big = big;
    @(negedge clk);
    if (big) begin b_msg = m; b_key = k; b_mod = n; b_tag = t; b_ivalid = 1'b1; end
    else begin s_msg = m[7:0]; s_key = k[7:0]; s_mod = n[7:0]; s_tag = t; s_ivalid = 1'b1; end
    while (!m_ir && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) chk("send_timeout", 256'(m_ir), 256'(1));
    if (push) begin e.tag = t; e.crypto = ec; e.err = ee; e.hit = eh; sb_q.push_back(e); end
    @(posedge clk);
    #1;
    s_ivalid = 1'b0; b_ivalid = 1'b0;
  endtask

  // Waits for o_valid, compares against the scoreboard head; optional backpressure hold.
  task automatic collect(input int hold, output int lat);
    exp_t e;
    lat = 0;
    if (cur_big) b_oready = (hold == 0); else s_oready = (hold == 0);
    do begin @(negedge clk); lat++; end while (!m_ov && lat < 40000);
    if (!m_ov) begin chk("ovalid_timeout", 256'(m_ov), 256'(1)); return; end
    if (sb_q.size() == 0) begin chk("sb_empty", 256'(0), 256'(1)); return; end
    e = sb_q.pop_front();
    chk("crypto", m_oc, e.crypto);
    chk("tag", 256'(m_ot), 256'(e.tag));
    chk("err", 256'(m_oe), 256'(e.err));
    chk("hit", 256'(m_oh), 256'(e.hit));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_ovalid", 256'(m_ov), 256'(1));
      chk("bp_iready", 256'(m_ir), 256'(0));
      chk("bp_crypto", m_oc, e.crypto);
      chk("bp_tag", 256'(m_ot), 256'(e.tag));
    end
    if (hold > 0) begin
      if (cur_big) b_oready = 1'b1; else s_oready = 1'b1;
      @(negedge clk);
      chk("bp_iready_rise", 256'(m_ir), 256'(1));
      chk("bp_ovalid_drop", 256'(m_ov), 256'(0));
    end else @(negedge clk);
  endtask

  initial begin
    int lat1, lat2, lat;
    bit seen_v;
    logic [255:0] n256, m256, k256;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_ovalid", 256'(s_ovalid), 256'(0));
    chk("rst_iready", 256'(s_iready), 256'(1));
    chk("rst_crypto", 256'(s_crypto), 256'(0));
    chk("rst_tag", 256'(s_otag), 256'(0));
    chk("rst_err", 256'(s_err), 256'(0));
    chk("rst_hit", 256'(s_hit), 256'(0));

    send(0, 1, 5, 3, 13, 4'd1, 8, 0, 0);  collect(0, lat1);
    send(0, 1, 2, 5, 13, 4'd2, 6, 0, 1);  collect(0, lat2);
    chk("hit_lat_shorter", 256'(lat2 < lat1), 256'(1));
    send(0, 1, 7, 4, 14, 4'd3, 0, 1, 0);  collect(0, lat);
    chk("err_lat", 256'(lat), 256'(2));
    send(0, 1, 2, 5, 13, 4'd4, 6, 0, 1);  collect(0, lat);
    send(0, 1, 9, 0, 13, 4'd8, 1, 0, 1);  collect(0, lat);
    send(0, 1, 3, 2, 13, 4'd5, 9, 0, 1);  collect(20, lat);

    // Reset while the exponentiation stage is busy.
    send(0, 0, 5, 3, 13, 4'd6, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    @(negedge clk) rst = 1'b0;
    seen_v = 1'b0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); seen_v |= s_ovalid; end
    chk("rst_mid_no_ovalid", 256'(seen_v), 256'(0));
    chk("rst_mid_iready", 256'(s_iready), 256'(1));
    chk("rst_mid_crypto", 256'(s_crypto), 256'(0));
    send(0, 1, 4, 2, 13, 4'd7, 3, 0, 0);  collect(0, lat);
    send(0, 1, 6, 3, 1, 4'd9, 0, 0, 0);   collect(0, lat);

    n256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    n256[0] = 1'b1; n256[255] = 1'b1;
    for (int j = 0; j < 2; j++) begin
      m256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      k256 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      send(1, 1, m256, k256, n256, 4'(10 + j), gold(m256, k256, n256), 0, 0);
      collect(0, lat);
    end
    chk("sb_drained", 256'(sb_q.size()), 256'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
